// File: rtl/hex_display_slave_if.sv
// Avalon-MM register bus bundle for hex_display_slave (word-addressed, fixed read latency 1).
interface hex_display_slave_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/hex_display_slave.sv
// Six-digit 7-segment display slave: tick-committed value, leading-zero blanking, per-digit blink.
// Optional irq on commit when HEX_IRQ_EN is defined.
module hex_display_slave #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic               clk,
  input  logic               reset,
  hex_display_slave_if.slave bus,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic [6:0]         hex4,
  output logic [6:0]         hex5
`ifdef HEX_IRQ_EN
  ,output logic              irq
`endif
);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [23:0]       r_value, r_shadow;
  logic              r_en, r_lzb, r_pending, r_phase;
  logic [5:0]        r_blink;
  logic [RW-1:0]     r_rcnt;
  logic [BW-1:0]     r_bcnt;
  logic [31:0]       r_rdata;
  logic [5:0][6:0]   r_seg;

  logic              w_tick, w_bwrap, w_commit, w_wr_val, w_wr_ctl, w_irq;
  logic [31:0]       w_rdata;
  logic [5:0][6:0]   w_seg_nxt;

  assign w_tick   = (r_rcnt == RW'(REFRESH_DIV - 1));
  assign w_bwrap  = (r_bcnt == BW'(BLINK_DIV - 1));
  assign w_commit = w_tick & r_pending;
  assign w_wr_val = bus.write && (bus.address == 2'd0);
  assign w_wr_ctl = bus.write && (bus.address == 2'd1);

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'h0: f_seg = 7'h40;  4'h1: f_seg = 7'h79;  4'h2: f_seg = 7'h24;  4'h3: f_seg = 7'h30;
      4'h4: f_seg = 7'h19;  4'h5: f_seg = 7'h12;  4'h6: f_seg = 7'h02;  4'h7: f_seg = 7'h78;
      4'h8: f_seg = 7'h00;  4'h9: f_seg = 7'h10;  4'hA: f_seg = 7'h08;  4'hB: f_seg = 7'h03;
      4'hC: f_seg = 7'h46;  4'hD: f_seg = 7'h21;  4'hE: f_seg = 7'h06;  default: f_seg = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value   <= '0;
      r_shadow  <= '0;
      r_en      <= 1'b1;
      r_lzb     <= 1'b0;
      r_blink   <= '0;
      r_pending <= 1'b0;
      r_phase   <= 1'b0;
      r_rcnt    <= '0;
      r_bcnt    <= '0;
    end else begin
      r_rcnt <= w_tick  ? '0 : r_rcnt + 1'b1;
      r_bcnt <= w_bwrap ? '0 : r_bcnt + 1'b1;
      if (w_bwrap) r_phase <= ~r_phase;
      // Commit samples the pre-write VALUE; a same-cycle write keeps PENDING for the next tick.
      if (w_commit) r_shadow <= r_value;
      if (w_wr_val)      r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
      if (w_wr_val) r_value <= bus.writedata[23:0];
      if (w_wr_ctl) begin
        r_en    <= bus.writedata[0];
        r_lzb   <= bus.writedata[1];
        r_blink <= bus.writedata[13:8];
      end
    end
  end

`ifdef HEX_IRQ_EN
  logic r_irq, r_commit_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq      <= 1'b0;
      r_commit_d <= 1'b0;
    end else begin
      r_commit_d <= w_commit;
      if (r_commit_d)                                r_irq <= 1'b1;
      else if (bus.write && bus.address == 2'd2)     r_irq <= 1'b0;
    end
  end
  assign w_irq = r_irq;
  assign irq   = r_irq;
`else
  assign w_irq = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      2'd0: w_rdata = {8'd0, r_value};
      2'd1: w_rdata = {18'd0, r_blink, 6'd0, r_lzb, r_en};
      2'd2: w_rdata = {29'd0, w_irq, r_phase, r_pending};
      default: w_rdata = {8'd0, r_shadow};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_rdata <= '0;
    else if (bus.read) r_rdata <= w_rdata;
  end
  assign bus.readdata = r_rdata;

  for (genvar i = 0; i < 6; i++) begin : g_dig
    logic w_hi_zero, w_blank;
    // hex0 always shows a glyph under LZB so a zero value still reads "0".
    assign w_hi_zero    = ((r_shadow >> (4 * i)) == 24'd0);
    assign w_blank      = !r_en || (r_lzb && (i != 0) && w_hi_zero) || (r_blink[i] && r_phase);
    assign w_seg_nxt[i] = w_blank ? 7'h7F : f_seg(r_shadow[4*i +: 4]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_seg <= {6{7'h7F}};
    else       r_seg <= w_seg_nxt;
  end

  assign hex0 = r_seg[0];
  assign hex1 = r_seg[1];
  assign hex2 = r_seg[2];
  assign hex3 = r_seg[3];
  assign hex4 = r_seg[4];
  assign hex5 = r_seg[5];
endmodule

// File: tb/tb_hex_display_slave.sv
// Directed bench for hex_display_slave with REFRESH_DIV=4, BLINK_DIV=8.
module tb_hex_display_slave;
  logic clk = 1'b0;
  logic reset;
  logic [6:0] h0, h1, h2, h3, h4, h5;
  logic [41:0] hall;
  logic [31:0] rdv;
  int n_cmp = 0;
  int n_err = 0;
  int tb_cnt;

  hex_display_slave_if bus();
`ifdef HEX_IRQ_EN
  logic irq;
`endif

  hex_display_slave #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .hex4(h4), .hex5(h5)
`ifdef HEX_IRQ_EN
    , .irq(irq)
`endif
  );

  assign hall = {h5, h4, h3, h2, h1, h0};

  always #5 clk = ~clk;

  // Refresh-phase reference: value seen at a negedge is the count before the next posedge.
  always @(posedge clk or posedge reset)
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic sync_cnt(input int v);
    for (int k = 0; k < 8 && tb_cnt != v; k++) @(negedge clk);
    n_cmp++;
    if (tb_cnt != v) begin n_err++; $display("FAIL sync_cnt: got %0d want %0d", tb_cnt, v); end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.address = '0; bus.write = 1'b0; bus.writedata = '0; bus.read = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (hall !== {6{7'h7F}}) begin n_err++; $display("FAIL reset_hex: got %h want %h", hall, {6{7'h7F}}); end
    n_cmp++; if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus.readdata); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (hall !== {6{7'h40}}) begin n_err++; $display("FAIL idle_hex: got %h want %h", hall, {6{7'h40}}); end
    rd(2'd2, rdv);
    n_cmp++; if (rdv !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h want 0", rdv); end
    rd(2'd1, rdv);
    n_cmp++; if (rdv !== 32'h1) begin n_err++; $display("FAIL reset_ctrl: got %h want 1", rdv); end
  endtask

  task automatic test_commit;
    wr(2'd0, 32'hFF12AB3F);
    rd(2'd2, rdv);
    n_cmp++; if (rdv[0] !== 1'b1) begin n_err++; $display("FAIL pending_set: got %b want 1", rdv[0]); end
    repeat (5) @(negedge clk);
    rd(2'd2, rdv);
    n_cmp++; if (rdv[0] !== 1'b0) begin n_err++; $display("FAIL pending_clr: got %b want 0", rdv[0]); end
    rd(2'd3, rdv);
    n_cmp++; if (rdv !== 32'h0012AB3F) begin n_err++; $display("FAIL shadow: got %h want 0012ab3f", rdv); end
    rd(2'd0, rdv);
    n_cmp++; if (rdv !== 32'h0012AB3F) begin n_err++; $display("FAIL value_rd: got %h want 0012ab3f", rdv); end
    n_cmp++;
    if (hall !== {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E}) begin
      n_err++; $display("FAIL glyphs: got %h want %h", hall, {7'h79, 7'h24, 7'h08, 7'h03, 7'h30, 7'h0E});
    end
  endtask

  task automatic test_lzb;
    wr(2'd1, 32'h3);
    rd(2'd1, rdv);
    n_cmp++; if (rdv !== 32'h3) begin n_err++; $display("FAIL ctrl_rd: got %h want 3", rdv); end
    wr(2'd0, 32'hA); repeat (6) @(negedge clk);
    n_cmp++; if (hall !== {{5{7'h7F}}, 7'h08}) begin n_err++; $display("FAIL lzb_a: got %h want %h", hall, {{5{7'h7F}}, 7'h08}); end
    wr(2'd0, 32'h0); repeat (6) @(negedge clk);
    n_cmp++; if (hall !== {{5{7'h7F}}, 7'h40}) begin n_err++; $display("FAIL lzb_zero: got %h want %h", hall, {{5{7'h7F}}, 7'h40}); end
    wr(2'd0, 32'h010203); repeat (6) @(negedge clk);
    n_cmp++;
    if (hall !== {7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30}) begin
      n_err++; $display("FAIL lzb_inner: got %h want %h", hall, {7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30});
    end
    wr(2'd1, 32'h0); @(negedge clk);
    n_cmp++; if (hall !== {6{7'h7F}}) begin n_err++; $display("FAIL en_off: got %h want %h", hall, {6{7'h7F}}); end
    wr(2'd3, 32'hFFFFFF);
    rd(2'd3, rdv);
    n_cmp++; if (rdv !== 32'h010203) begin n_err++; $display("FAIL ro_shadow: got %h want 00010203", rdv); end
    wr(2'd1, 32'hFFFFFFFF);
    rd(2'd1, rdv);
    n_cmp++; if (rdv !== 32'h3F03) begin n_err++; $display("FAIL ctrl_mask: got %h want 00003f03", rdv); end
    wr(2'd1, 32'h1);
  endtask

  task automatic test_tick_coincide;
    sync_cnt(1);
    wr(2'd0, 32'h111111);
    @(negedge clk);
    wr(2'd0, 32'h222222);
    rd(2'd3, rdv);
    n_cmp++; if (rdv !== 32'h111111) begin n_err++; $display("FAIL coincide_old: got %h want 00111111", rdv); end
    rd(2'd2, rdv);
    n_cmp++; if (rdv[0] !== 1'b1) begin n_err++; $display("FAIL coincide_pend: got %b want 1", rdv[0]); end
    rd(2'd3, rdv);
    n_cmp++; if (rdv !== 32'h111111) begin n_err++; $display("FAIL coincide_hold: got %h want 00111111", rdv); end
    @(negedge clk);
    rd(2'd3, rdv);
    n_cmp++; if (rdv !== 32'h222222) begin n_err++; $display("FAIL coincide_new: got %h want 00222222", rdv); end
    @(negedge clk);
    n_cmp++; if (hall !== {6{7'h24}}) begin n_err++; $display("FAIL coincide_hex: got %h want %h", hall, {6{7'h24}}); end
  endtask

  task automatic test_blink;
    logic [6:0] s [32];
    int nblank, bad;
    wr(2'd1, 32'h101);
    @(negedge clk);
    nblank = 0; bad = 0;
    for (int i = 0; i < 32; i++) begin
      s[i] = h0;
      if (h0 == 7'h7F) nblank++;
      else if (h0 != 7'h24) bad++;
      if ({h5, h4, h3, h2, h1} != {5{7'h24}}) bad++;
      @(negedge clk);
    end
    for (int i = 0; i < 24; i++) if (s[i] == s[i+8]) bad++;
    n_cmp++; if (nblank !== 16) begin n_err++; $display("FAIL blink_duty: got %0d want 16", nblank); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL blink_period: got %0d bad samples want 0", bad); end
    wr(2'd1, 32'h1);
  endtask

`ifdef HEX_IRQ_EN
  task automatic test_irq;
    sync_cnt(1);
    wr(2'd0, 32'h5);
    @(negedge clk);
    @(negedge clk);
    wr(2'd2, 32'h0);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    rd(2'd2, rdv);
    n_cmp++; if (rdv[2] !== 1'b1) begin n_err++; $display("FAIL irq_status: got %b want 1", rdv[2]); end
    wr(2'd2, 32'h0);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    sync_cnt(1);
    wr(2'd0, 32'h6);
    repeat (4) @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_commit: got %b want 1", irq); end
  endtask
`endif

  task automatic test_reset_mid;
    rd(2'd1, rdv);
    wr(2'd0, 32'h333333);
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (hall !== {6{7'h7F}}) begin n_err++; $display("FAIL midrst_hex: got %h want %h", hall, {6{7'h7F}}); end
    n_cmp++; if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL midrst_rdata: got %h want 0", bus.readdata); end
`ifdef HEX_IRQ_EN
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL midrst_irq: got %b want 0", irq); end
`endif
    @(negedge clk);
    reset = 1'b0;
    rd(2'd0, rdv);
    n_cmp++; if (rdv !== 32'h0) begin n_err++; $display("FAIL midrst_value: got %h want 0", rdv); end
    rd(2'd3, rdv);
    n_cmp++; if (rdv !== 32'h0) begin n_err++; $display("FAIL midrst_shadow: got %h want 0", rdv); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_lzb();
    test_tick_coincide();
    test_blink();
`ifdef HEX_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
